// File: rtl/bg_layer_gen.sv
// Background-layer generator: per-pixel pattern colour (solid/gradient/checker/bars)
// with frame-latched settings, per-frame horizontal scroll and a 2-stage pipeline.
module bg_layer_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 9,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned TILE_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [X_W-1:0]         x_pos,
  input  logic [Y_W-1:0]         y_pos,
  input  logic                   pix_valid,
  input  logic                   frame_start,
  input  logic [1:0]             mode_in,
  input  logic [3*COLOR_W-1:0]   color_a_in,
  input  logic [3*COLOR_W-1:0]   color_b_in,
  input  logic [X_W-1:0]         scroll_step_in,
  output logic                   out_valid,
  output logic                   RqFLag2,
  output logic [COLOR_W-1:0]     r2,
  output logic [COLOR_W-1:0]     g2,
  output logic [COLOR_W-1:0]     b2
);

  localparam int unsigned PIX_W = 3 * COLOR_W;

  // Frame-latched settings
  logic [1:0]       mode;
  logic [PIX_W-1:0] color_a;
  logic [PIX_W-1:0] color_b;
  logic [X_W-1:0]   scroll_step;
  logic [X_W-1:0]   scroll_x;
  logic [X_W-1:0]   step_eff;

  // Stage 1
  logic               s1_valid;
  logic               s1_active;
  logic               s1_tx;
  logic               s1_ty;
  logic [COLOR_W-1:0] s1_grad_r;
  logic [COLOR_W-1:0] s1_grad_g;
  logic [1:0]         s1_mode;
  logic [PIX_W-1:0]   s1_color_a;
  logic [PIX_W-1:0]   s1_color_b;

  logic               active_c;
  logic               tx_c;
  logic [PIX_W-1:0]   pix_sel_c;

  // The incoming step is the one added on a frame boundary, never the old shadow.
  always_comb begin
    step_eff = frame_start ? scroll_step_in : scroll_step;
    active_c = ({1'b0, x_pos} < (X_W+1)'(H_ACTIVE)) &&
               ({1'b0, y_pos} < (Y_W+1)'(V_ACTIVE));
    tx_c     = |((x_pos + scroll_x) & X_W'(1 << TILE_LOG2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= '0;
      color_a     <= '0;
      color_b     <= '0;
      scroll_step <= '0;
      scroll_x    <= '0;
    end else if (frame_start) begin
      mode        <= mode_in;
      color_a     <= color_a_in;
      color_b     <= color_b_in;
      scroll_step <= scroll_step_in;
      scroll_x    <= scroll_x + step_eff;
    end
  end

  // Settings travel with the pixel so a later frame_start cannot alter it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_active  <= 1'b0;
      s1_tx      <= 1'b0;
      s1_ty      <= 1'b0;
      s1_grad_r  <= '0;
      s1_grad_g  <= '0;
      s1_mode    <= '0;
      s1_color_a <= '0;
      s1_color_b <= '0;
    end else begin
      s1_valid   <= pix_valid;
      s1_active  <= active_c;
      s1_tx      <= tx_c;
      s1_ty      <= y_pos[TILE_LOG2];
      s1_grad_r  <= x_pos[X_W-1 -: COLOR_W];
      s1_grad_g  <= y_pos[Y_W-1 -: COLOR_W];
      s1_mode    <= mode;
      s1_color_a <= color_a;
      s1_color_b <= color_b;
    end
  end

  // Pattern select
  always_comb begin
    pix_sel_c = s1_color_a;
    case (s1_mode)
      2'd1:    pix_sel_c = {s1_grad_r, s1_grad_g, s1_color_a[COLOR_W-1:0]};
      2'd2:    if (s1_tx ^ s1_ty) pix_sel_c = s1_color_b;
      2'd3:    if (s1_tx) pix_sel_c = s1_color_b;
      default: pix_sel_c = s1_color_a;
    endcase
    if (!s1_active) pix_sel_c = '0;
  end

  // Stage 2: outputs hold while no pixel arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      RqFLag2   <= 1'b0;
      r2        <= '0;
      g2        <= '0;
      b2        <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        RqFLag2      <= s1_active;
        {r2, g2, b2} <= pix_sel_c;
      end
    end
  end

endmodule

// File: tb/tb_bg_layer_gen.sv
// Directed self-checking bench for bg_layer_gen at default parameters.
module tb_bg_layer_gen;

  logic        clk;
  logic        rst;
  logic [9:0]  x_pos;
  logic [8:0]  y_pos;
  logic        pix_valid;
  logic        frame_start;
  logic [1:0]  mode_in;
  logic [23:0] color_a_in;
  logic [23:0] color_b_in;
  logic [9:0]  scroll_step_in;
  logic        out_valid;
  logic        RqFLag2;
  logic [7:0]  r2;
  logic [7:0]  g2;
  logic [7:0]  b2;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0]  CB_X   [4] = '{10'd0, 10'd32, 10'd32, 10'd31};
  localparam logic [8:0]  CB_Y   [4] = '{9'd0,  9'd0,   9'd32,  9'd31};
  localparam logic [23:0] CB_RGB [4] = '{24'hFF0000, 24'h0000FF, 24'hFF0000, 24'hFF0000};

  bg_layer_gen dut (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .pix_valid(pix_valid),
    .frame_start(frame_start), .mode_in(mode_in), .color_a_in(color_a_in),
    .color_b_in(color_b_in), .scroll_step_in(scroll_step_in),
    .out_valid(out_valid), .RqFLag2(RqFLag2), .r2(r2), .g2(g2), .b2(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] obs();
    return {out_valid, RqFLag2, r2, g2, b2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_frame(input logic [1:0] m, input logic [23:0] a,
                             input logic [23:0] b, input logic [9:0] s);
    mode_in = m; color_a_in = a; color_b_in = b; scroll_step_in = s;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Accept one pixel, then advance until it reaches the outputs.
  task automatic run_pixel(input logic [9:0] x, input logic [8:0] y);
    x_pos = x; y_pos = y; pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b1; x_pos = '0; y_pos = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== 26'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs(), 26'h0);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_latency: out_valid got %b want 0", out_valid);
    end
    pix_valid = 1'b0;
    step();
    checks++;
    if (obs() !== {2'b11, 24'h000000}) begin
      errors++;
      $display("FAIL reset_first_pixel: got %h want %h", obs(), {2'b11, 24'h000000});
    end
    step();
  endtask

  task automatic test_checkerboard();
    apply_frame(2'd2, 24'hFF0000, 24'h0000FF, 10'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      x_pos = CB_X[i]; y_pos = CB_Y[i]; pix_valid = 1'b1;
      step();
      pix_valid = 1'b0;
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL cb_latency: out_valid got %b want 0", out_valid);
        end
      end
      step();
      checks++;
      if (obs() !== {2'b11, CB_RGB[i]}) begin
        errors++;
        $display("FAIL cb_pixel[%0d]: got %h want %h", i, obs(), {2'b11, CB_RGB[i]});
      end
    end
  endtask

  task automatic test_scroll_wrap();
    apply_frame(2'd2, 24'hFF0000, 24'h0000FF, 10'd8);
    run_pixel(10'd24, 9'd0);
    checks++;
    if (obs() !== {2'b11, 24'h0000FF}) begin
      errors++;
      $display("FAIL scroll_24: got %h want %h", obs(), {2'b11, 24'h0000FF});
    end
    for (int i = 0; i < 127; i++) apply_frame(2'd2, 24'hFF0000, 24'h0000FF, 10'd8);
    run_pixel(10'd0, 9'd0);
    checks++;
    if (obs() !== {2'b11, 24'hFF0000}) begin
      errors++;
      $display("FAIL wrap_0: got %h want %h", obs(), {2'b11, 24'hFF0000});
    end
    run_pixel(10'd24, 9'd0);
    checks++;
    if (obs() !== {2'b11, 24'hFF0000}) begin
      errors++;
      $display("FAIL wrap_24: got %h want %h", obs(), {2'b11, 24'hFF0000});
    end
  endtask

  task automatic test_gradient();
    apply_frame(2'd1, 24'h000055, 24'h000000, 10'd0);
    run_pixel(10'd512, 9'd256);
    checks++;
    if (obs() !== {2'b11, 24'h808055}) begin
      errors++;
      $display("FAIL grad_512_256: got %h want %h", obs(), {2'b11, 24'h808055});
    end
    run_pixel(10'd639, 9'd479);
    checks++;
    if (obs() !== {2'b11, 24'h9FEF55}) begin
      errors++;
      $display("FAIL grad_639_479: got %h want %h", obs(), {2'b11, 24'h9FEF55});
    end
  endtask

  task automatic test_out_of_area();
    apply_frame(2'd0, 24'hFFFFFF, 24'h000000, 10'd0);
    run_pixel(10'd640, 9'd0);
    checks++;
    if (obs() !== {2'b10, 24'h000000}) begin
      errors++;
      $display("FAIL ooa_x640: got %h want %h", obs(), {2'b10, 24'h000000});
    end
    run_pixel(10'd639, 9'd479);
    checks++;
    if (obs() !== {2'b11, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL ooa_edge_in: got %h want %h", obs(), {2'b11, 24'hFFFFFF});
    end
    run_pixel(10'd0, 9'd480);
    checks++;
    if (obs() !== {2'b10, 24'h000000}) begin
      errors++;
      $display("FAIL ooa_y480: got %h want %h", obs(), {2'b10, 24'h000000});
    end
  endtask

  task automatic test_back_to_back_tear_free();
    mode_in = 2'd2; color_a_in = 24'h123456; color_b_in = 24'hABCDEF; scroll_step_in = 10'd4;
    run_pixel(10'd32, 9'd0);
    checks++;
    if (obs() !== {2'b11, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL tear_ignored: got %h want %h", obs(), {2'b11, 24'hFFFFFF});
    end
    mode_in = 2'd3; color_a_in = 24'h112233; color_b_in = 24'h445566; scroll_step_in = 10'd0;
    frame_start = 1'b1; pix_valid = 1'b1; x_pos = 10'd32; y_pos = 9'd0;
    step();
    frame_start = 1'b0;
    step();
    checks++;
    if (obs() !== {2'b11, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL tear_old_pixel: got %h want %h", obs(), {2'b11, 24'hFFFFFF});
    end
    pix_valid = 1'b0;
    step();
    checks++;
    if (obs() !== {2'b11, 24'h445566}) begin
      errors++;
      $display("FAIL tear_new_pixel: got %h want %h", obs(), {2'b11, 24'h445566});
    end
    run_pixel(10'd32, 9'd32);
    checks++;
    if (obs() !== {2'b11, 24'h445566}) begin
      errors++;
      $display("FAIL bars_32_32: got %h want %h", obs(), {2'b11, 24'h445566});
    end
    run_pixel(10'd0, 9'd32);
    checks++;
    if (obs() !== {2'b11, 24'h112233}) begin
      errors++;
      $display("FAIL bars_0_32: got %h want %h", obs(), {2'b11, 24'h112233});
    end
  endtask

  task automatic test_reset_flush();
    x_pos = '0; y_pos = '0; pix_valid = 1'b1;
    step();
    pix_valid = 1'b0; rst = 1'b1;
    mode_in = 2'd2; color_a_in = 24'hFFFFFF; color_b_in = 24'hFFFFFF; scroll_step_in = 10'd8;
    frame_start = 1'b1;
    step();
    checks++;
    if (obs() !== 26'h0) begin
      errors++;
      $display("FAIL flush_mid_frame: got %h want %h", obs(), 26'h0);
    end
    frame_start = 1'b0; rst = 1'b0;
    run_pixel(10'd32, 9'd0);
    checks++;
    if (obs() !== {2'b11, 24'h000000}) begin
      errors++;
      $display("FAIL reset_beats_frame: got %h want %h", obs(), {2'b11, 24'h000000});
    end
  endtask

  initial begin
    rst = 1'b1; x_pos = '0; y_pos = '0; pix_valid = 1'b0; frame_start = 1'b0;
    mode_in = '0; color_a_in = '0; color_b_in = '0; scroll_step_in = '0;
    test_reset();
    test_checkerboard();
    test_scroll_wrap();
    test_gradient();
    test_out_of_area();
    test_back_to_back_tear_free();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bg_layer_gen.md
# bg_layer_gen

Parametrised background-layer generator for the dynamic display pipeline. It replaces the fixed single-pattern background layer. For each pixel coordinate presented by the timing generator it produces a registered RGB value and a layer-request flag, which feed the layer compositor. It supports four pattern modes, configurable resolution and colour depth, and per-frame horizontal scrolling. Configuration is latched only at frame boundaries, so changes never tear.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `X_W`, 10, width of x coordinate and scroll offset; must be ≥ `COLOR_W`
- `Y_W`, 9, width of y coordinate; must be ≥ `COLOR_W`
- `COLOR_W`, 8, bits per colour channel
- `TILE_LOG2`, 5, log2 of tile/bar size in pixels
---
- `clk`  in  1  pixel clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `x_pos`  in  X_W  pixel column
- `y_pos`  in  Y_W  pixel row
- `pix_valid`  in  1  `x_pos`/`y_pos` valid this cycle
- `frame_start`  in  1  one-cycle pulse before the first pixel of a frame
- `mode_in`  in  2  pattern: 0 = solid, 1 = gradient, 2 = checkerboard, 3 = vertical bars
- `color_a_in`  in  3*COLOR_W  colour A, packed {r,g,b}
- `color_b_in`  in  3*COLOR_W  colour B, packed {r,g,b}
- `scroll_step_in`  in  X_W  per-frame scroll increment
- `out_valid`  out  1  `r2`/`g2`/`b2`/`RqFLag2` valid
- `RqFLag2`  out  1  layer requests the pixel (active area)
- `r2`, `g2`, `b2`  out  COLOR_W each  pixel colour

## Operation
- **Shadow registers:** `mode`, `color_a`, `color_b` and `scroll_step` are captured from the `*_in` ports only in a cycle where `frame_start`=1. Input changes at any other time are ignored.
- **Scroll offset:** `scroll_x` updates in a `frame_start` cycle as `scroll_x <= scroll_x + scroll_step_in`, modulo 2^X_W. The step added is the incoming value, not the old shadow value.
- **Active area:** a pixel is active when `x_pos < H_ACTIVE` and `y_pos < V_ACTIVE`.
  - Inactive pixel: `RqFLag2`=0 and rgb=0, while `out_valid` still follows `pix_valid`.
- **Scrolled coordinate:** `sx = (x_pos + scroll_x) mod 2^X_W`. Tile index bits are `tx = sx[TILE_LOG2]` and `ty = y_pos[TILE_LOG2]`.
- **Mode 0 (solid):** output = A.
- **Mode 1 (gradient):** unscrolled.
  - r = `x_pos[X_W-1 -: COLOR_W]`
  - g = `y_pos[Y_W-1 -: COLOR_W]`
  - b = blue channel of A
- **Mode 2 (checkerboard):** output = A if `tx^ty`=0, else B.
- **Mode 3 (vertical bars):** output = A if `tx`=0, else B.
- **Pipeline:** 2 register stages.
  - Stage 1 registers the coordinates, valid, the active flag, `sx`, and a copy of the shadow settings. The settings travel with the pixel, so a `frame_start` mid-pipeline never alters pixels already accepted.
  - Stage 2 selects and registers the outputs.
- **Reset values:** all outputs 0; `scroll_x`=0; `mode`=0; `color_a`=0; `color_b`=0; `scroll_step`=0; pipeline valids 0.
- **Reset mid-frame:** the pipeline is flushed. `out_valid` is 0 from the first edge with `rst`=1. Pixels in flight are discarded, not completed.
- **`rst` together with `frame_start`:** reset wins; shadows take reset values.

## Timing
- Latency is 2 cycles: a pixel accepted at edge n (`pix_valid`=1) appears on the outputs after edge n+2.
- Throughput is 1 pixel per cycle. There is no backpressure; gaps in `pix_valid` propagate as `out_valid`=0 gaps.
- `frame_start` sampled at edge n: pixels accepted at edge n use the OLD settings and scroll. Pixels accepted at edge n+1 and later use the new ones.
- `frame_start` and `pix_valid` may both be high in the same cycle; that pixel still uses the old settings.
- `scroll_x` wraps silently: 1020 + 8 = 4 for `X_W`=10.
- Outputs hold their last value while `out_valid`=0; the consumer ignores them.

## Test plan
All scenarios use default parameters.
- **Reset.** Hold `rst` for 3 cycles with `pix_valid`=1 → all outputs 0 throughout. First valid output appears 2 cycles after `rst` deasserts.
- **Checkerboard.** `frame_start` with mode 2, A=FF0000, B=0000FF, step 0. Then pixels (0,0), (32,0), (32,32), (31,31) → A, B, A, A with `RqFLag2`=1 and latency 2.
- **Scroll and wrap.**
  - Step 8, one further `frame_start` → pixel (24,0) reads `sx`=32 → B.
  - Drive 128 `frame_start` pulses → `scroll_x` returns to 0, so pixel (0,0) → A.
- **Gradient.** Mode 1, A=000055: pixel (512,256) → r=0x80, g=0x80, b=0x55. Pixel (639,479) → r=0x9F, g=0xEF, b=0x55.
- **Out of area.** Pixels (640,0) and (0,480) in mode 0 with A=FFFFFF → `out_valid`=1, `RqFLag2`=0, rgb=000000.
- **Tear-free update.** Change `mode_in`/colours mid-frame without `frame_start` → output unchanged. With `frame_start` coincident with `pix_valid` → that pixel uses the old mode and the next pixel uses the new one.
